// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-op issue stage with register file and external ALU.
// Optional LUI decode enabled by defining ALU_ISSUE_LUI_EN.
module alu_issue #(
  parameter int NUM_REGS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_instr_vld,
  output logic        o_instr_rdy,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_res,
  output logic        o_wb_vld,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_illegal,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
`ifdef ALU_ISSUE_LUI_EN
  localparam logic [6:0] OPC_LUI = 7'b0110111;
`endif

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state, state_nxt;

  logic [31:0] instr;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i;
  logic        rd_ok, rs1_ok, rs2_ok, dbg_ok;
  logic [31:0] rs1_val, rs2_val;

  assign {f7, rs2, rs1, f3, rd, opc} = instr;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};

  assign rd_ok  = {1'b0, rd}  < NR;
  assign rs1_ok = {1'b0, rs1} < NR;
  assign rs2_ok = {1'b0, rs2} < NR;
  assign dbg_ok = {1'b0, i_dbg_addr} < NR;

  assign rs1_val = (rs1_ok && rs1 != '0) ?
                   regs[rs1[AW-1:0]] : '0;
  assign rs2_val = (rs2_ok && rs2 != '0) ?
                   regs[rs2[AW-1:0]] : '0;
  assign o_dbg_data = (dbg_ok && i_dbg_addr != '0) ?
                      regs[i_dbg_addr[AW-1:0]] : '0;

  function automatic logic [3:0] base_op(input logic [2:0] f);
    case (f)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic        dec_ok, use_rs1, use_rs2, legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;

  always_comb begin
    dec_ok  = 1'b0;
    dec_op  = ALU_ADD;
    dec_a   = rs1_val;
    dec_b   = rs2_val;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    unique case (1'b1)
      (opc == OPC_R): begin
        use_rs2 = 1'b1;
        if (f7 == 7'h00) begin
          dec_ok = 1'b1;
          dec_op = base_op(f3);
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          dec_ok = 1'b1;
          dec_op = ALU_SUB;
        end else if (f7 == 7'h20 && f3 == 3'b101) begin
          dec_ok = 1'b1;
          dec_op = ALU_SRA;
        end
      end
      (opc == OPC_I): begin
        dec_b  = imm_i;
        dec_op = base_op(f3);
        unique case (f3)
          3'b001:  dec_ok = (f7 == 7'h00);
          3'b101: begin
            dec_ok = (f7 == 7'h00) || (f7 == 7'h20);
            if (f7 == 7'h20) dec_op = ALU_SRA;
          end
          default: dec_ok = 1'b1;
        endcase
      end
`ifdef ALU_ISSUE_LUI_EN
      (opc == OPC_LUI): begin
        dec_ok  = 1'b1;
        use_rs1 = 1'b0;
        dec_a   = '0;
        dec_b   = {instr[31:12], 12'b0};
      end
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  // Register-index range limits legality when NUM_REGS is 16
  assign legal = dec_ok && rd_ok &&
                 (rs1_ok || !use_rs1) &&
                 (rs2_ok || !use_rs2);

  logic exec, accept;

  assign exec   = (state == EXEC);
  assign accept = i_instr_vld && o_instr_rdy;

  always_comb begin
    state_nxt   = state;
    o_instr_rdy = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_op    = ALU_ADD;
    unique case (state)
      IDLE: begin
        o_instr_rdy = i_rst_n;
        if (i_instr_vld) state_nxt = EXEC;
      end
      EXEC: begin
        if (legal) begin
          o_alu_a  = dec_a;
          o_alu_b  = dec_b;
          o_alu_op = dec_op;
        end
        state_nxt = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      instr     <= '0;
      o_wb_vld  <= 1'b0;
      o_illegal <= 1'b0;
      o_wb_rd   <= '0;
      o_wb_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      o_wb_vld  <= exec && legal;
      o_illegal <= exec && !legal;
      if (accept) instr <= i_instr;
      if (exec && legal) begin
        o_wb_rd   <= rd;
        o_wb_data <= i_alu_res;
        if (rd != '0) regs[rd[AW-1:0]] <= i_alu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed + random checks of alu_issue against a
// mnemonic-level reference model and a behavioural ALU.
module tb_alu_issue;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;
  localparam logic [3:0] SLT  = 4'd3;
  localparam logic [3:0] SLTU = 4'd4;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] OR   = 4'd8;
  localparam logic [3:0] AND  = 4'd9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] instr, alu_a, alu_b, alu_res, wb_data, dbg_data;
  logic        vld, rdy, wb_vld, illegal;
  logic [3:0]  alu_op;
  logic [4:0]  wb_rd, dbg_addr;

  logic [31:0] instr_s, a_s, b_s, res_s, wbd_s, dbgd_s;
  logic        vld_s, rdy_s, wbv_s, ill_s;
  logic [3:0]  op_s;
  logic [4:0]  wbr_s, dbga_s;

  function automatic logic [31:0] alu_ref(
    input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SLT:     return {31'b0, $signed(a) < $signed(b)};
      SLTU:    return {31'b0, a < b};
      XOR:     return a ^ b;
      SRL:     return a >> b[4:0];
      SRA:     return $signed(a) >>> b[4:0];
      OR:      return a | b;
      AND:     return a & b;
      default: return 32'hdead_beef;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_op, alu_a, alu_b);
  assign res_s   = alu_ref(op_s, a_s, b_s);

  alu_issue dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr(instr), .i_instr_vld(vld),
    .o_instr_rdy(rdy),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_res(alu_res),
    .o_wb_vld(wb_vld), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_illegal(illegal),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  alu_issue #(.NUM_REGS(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_instr(instr_s), .i_instr_vld(vld_s),
    .o_instr_rdy(rdy_s),
    .o_alu_a(a_s), .o_alu_b(b_s), .o_alu_op(op_s),
    .i_alu_res(res_s),
    .o_wb_vld(wbv_s), .o_wb_rd(wbr_s), .o_wb_data(wbd_s),
    .o_illegal(ill_s),
    .i_dbg_addr(dbga_s), .o_dbg_data(dbgd_s)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] mregs [32];
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [3:0] f3_op(input int f3);
    case (f3)
      0: return ADD;  1: return SLL;
      2: return SLT;  3: return SLTU;
      4: return XOR;  5: return SRL;
      6: return OR;   default: return AND;
    endcase
  endfunction

  // Expected legality and ALU operands from the RV32I rules.
  task automatic predict(input logic [31:0] ins, input int nr,
                         output bit ok, output logic [31:0] ea,
                         output logic [31:0] eb,
                         output logic [3:0] eop);
    int opc, f3, f7, rd, rs1, rs2;
    logic [31:0] v1, v2;
    opc = int'(ins[6:0]);  f3 = int'(ins[14:12]);
    f7  = int'(ins[31:25]); rd = int'(ins[11:7]);
    rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
    v1 = (rs1 != 0 && rs1 < nr) ? mregs[rs1] : 32'd0;
    v2 = (rs2 != 0 && rs2 < nr) ? mregs[rs2] : 32'd0;
    ok = 0; ea = v1; eb = v2; eop = ADD;
    if (opc == 'h33 && rs1 < nr && rs2 < nr && rd < nr) begin
      if (f7 == 0) begin ok = 1; eop = f3_op(f3); end
      else if (f7 == 'h20 && f3 == 0) begin ok = 1; eop = SUB; end
      else if (f7 == 'h20 && f3 == 5) begin ok = 1; eop = SRA; end
    end else if (opc == 'h13 && rs1 < nr && rd < nr) begin
      eb = {{20{ins[31]}}, ins[31:20]};
      eop = f3_op(f3);
      if (f3 == 1) ok = (f7 == 0);
      else if (f3 == 5) begin
        ok = (f7 == 0) || (f7 == 'h20);
        if (f7 == 'h20) eop = SRA;
      end else ok = 1;
    end
`ifdef ALU_ISSUE_LUI_EN
    else if (opc == 'h37 && rd < nr) begin
      ok = 1; ea = 0; eb = {ins[31:12], 12'b0};
    end
`endif
    if (!ok) begin ea = 0; eb = 0; eop = ADD; end
  endtask

  task automatic issue(input logic [31:0] ins, input string tag);
    bit ok;
    logic [31:0] ea, eb, er;
    logic [3:0] eop;
    int w = 0;
    while (!rdy && w < 8) begin @(posedge clk); #1; w++; end
    chk({tag, "_rdy_wait"}, 32'(rdy), 32'd1);
    predict(ins, 32, ok, ea, eb, eop);
    er = alu_ref(eop, ea, eb);
    instr = ins; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; instr = $urandom;
    chk({tag, "_exec_rdy"}, 32'(rdy), 32'd0);
    chk({tag, "_a"}, alu_a, ea);
    chk({tag, "_b"}, alu_b, eb);
    chk({tag, "_op"}, 32'(alu_op), 32'(eop));
    @(posedge clk); #1;
    chk({tag, "_wb_vld"}, 32'(wb_vld), 32'(ok));
    chk({tag, "_illegal"}, 32'(illegal), 32'(!ok));
    chk({tag, "_wb_rdy"}, 32'(rdy), 32'd0);
    if (ok) begin
      last_rd = ins[11:7];
      last_data = er;
      if (ins[11:7] != 0) mregs[ins[11:7]] = er;
    end
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(last_rd));
    chk({tag, "_wb_data"}, wb_data, last_data);
    @(posedge clk); #1;
    chk({tag, "_idle_rdy"}, 32'(rdy), 32'd1);
    chk({tag, "_idle_pulse"}, 32'(wb_vld | illegal), 32'd0);
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      @(negedge clk);
      chk($sformatf("%s_x%0d", tag, i), dbg_data,
          (i == 0) ? 32'd0 : mregs[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic dbg(input int r, input logic [31:0] exp,
                     input string tag);
    dbg_addr = 5'(r);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, lui_exp;
    int kind, f3;
    logic [6:0] f7;
    rst_n = 1'b0; vld = 1'b0; instr = '0; dbg_addr = '0;
    vld_s = 1'b0; instr_s = '0; dbga_s = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    last_rd = '0; last_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_wb_vld", 32'(wb_vld), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 32'(rdy), 32'd1);

    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), "addi_x1");
    dbg(1, 32'h5, "dbg_x1");

    issue(enc_i(12'hff8, 5'd0, 3'b000, 5'd2), "addi_x2");
    issue(enc_i(12'h401, 5'd2, 3'b101, 5'd3), "srai_x3");
    issue(enc_i(12'h01c, 5'd2, 3'b101, 5'd4), "srli_x4");
    issue(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5), "slt_x5");
    issue(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6), "sltu_x6");
    dbg(3, 32'hffff_fffc, "dbg_x3");
    dbg(4, 32'h0000_000f, "dbg_x4");
    dbg(5, 32'h1, "dbg_x5");
    dbg(6, 32'h0, "dbg_x6");

    issue(32'h0000_0000, "ill_zero");
    issue(enc_r(7'h01, 5'd1, 5'd2, 3'b000, 5'd9), "ill_f7");
    dump("after_ill");

    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd0), "addi_x0");
    dbg(0, 32'h0, "dbg_x0");

    // Held-valid back-to-back; the second reads the first's result
    instr = enc_i(12'd3, 5'd0, 3'b000, 5'd9); vld = 1'b1;
    @(posedge clk); #1;
    instr = enc_i(12'd4, 5'd9, 3'b000, 5'd10);
    chk("b2b_exec_rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    chk("b2b_wb_rdy", 32'(rdy), 32'd0);
    chk("b2b_wb1", 32'(wb_vld), 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle_rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    vld = 1'b0;
    chk("b2b_acc2_rdy", 32'(rdy), 32'd0);
    chk("b2b_acc2_a", alu_a, 32'd3);
    @(posedge clk); #1;
    chk("b2b_wb2", 32'(wb_vld), 32'd1);
    chk("b2b_wb2_rd", 32'(wb_rd), 32'd10);
    chk("b2b_wb2_data", wb_data, 32'd7);
    @(posedge clk); #1;
    chk("b2b_end_rdy", 32'(rdy), 32'd1);
    mregs[9] = 32'd3; mregs[10] = 32'd7;
    last_rd = 5'd10; last_data = 32'd7;

    issue({20'h12345, 5'd8, 7'b0110111}, "lui_x8");
`ifdef ALU_ISSUE_LUI_EN
    lui_exp = 32'h1234_5000;
`else
    lui_exp = 32'h0;
`endif
    dbg(8, lui_exp, "dbg_lui_x8");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      f3 = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (kind <= 3)
        ins = enc_r(f7, 5'($urandom), 5'($urandom),
                    3'(f3), 5'($urandom));
      else if (kind <= 8) begin
        ins = enc_i(12'($urandom), 5'($urandom),
                    3'(f3), 5'($urandom));
        if (f3 == 1 || f3 == 5) ins[31:25] = f7;
      end else
        ins = $urandom;
      issue(ins, $sformatf("rnd%0d", n));
    end
    dump("after_rnd");

    // Reset while the instruction is in EXEC
    instr = enc_i(12'd9, 5'd0, 3'b000, 5'd7); vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    chk("midrst_pulse", 32'(wb_vld | illegal), 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    chk("midrst_no_pulse", 32'(wb_vld | illegal), 32'd0);
    chk("midrst_rdy2", 32'(rdy), 32'd1);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    last_rd = '0; last_data = '0;
    dbg(7, 32'h0, "midrst_x7");
    dump("after_rst");
    issue(enc_i(12'd11, 5'd0, 3'b000, 5'd12), "post_rst");

    // NUM_REGS=16 instance
    chk("r16_rdy", 32'(rdy_s), 32'd1);
    instr_s = enc_i(12'd1, 5'd0, 3'b000, 5'd20); vld_s = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0;
    @(posedge clk); #1;
    chk("r16_x20_ill", 32'(ill_s), 32'd1);
    chk("r16_x20_wb", 32'(wbv_s), 32'd0);
    @(posedge clk); #1;
    instr_s = enc_i(12'd1, 5'd0, 3'b000, 5'd3); vld_s = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0;
    @(posedge clk); #1;
    chk("r16_x3_wb", 32'(wbv_s), 32'd1);
    chk("r16_x3_data", wbd_s, 32'd1);
    @(posedge clk); #1;
    instr_s = enc_r(7'h00, 5'd17, 5'd3, 3'b000, 5'd4); vld_s = 1'b1;
    @(posedge clk); #1;
    vld_s = 1'b0;
    @(posedge clk); #1;
    chk("r16_rs2_ill", 32'(ill_s), 32'd1);
    @(posedge clk); #1;
    dbga_s = 5'd3; #1;
    chk("r16_dbg3", dbgd_s, 32'd1);
    dbga_s = 5'd19; #1;
    chk("r16_dbg19", dbgd_s, 32'd0);
    dbga_s = 5'd4; #1;
    chk("r16_dbg4", dbgd_s, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the ALU interface.
- Accepts RV32I register-register and register-immediate ALU instruction words over a valid/ready handshake, and holds the architectural register file.
- Decodes each instruction into op/operand A/operand B and drives the external combinational ALU with them.
- Captures the ALU result and writes it back to the register file.

Parameters:
NUM_REGS, 32, register file depth; legal values 16 or 32 only; any register index >= NUM_REGS makes the instruction illegal.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  synchronous reset, active-low
i_instr  input  32  instruction word
i_instr_vld  input  1  i_instr valid
o_instr_rdy  output  1  block can accept an instruction
o_alu_a  output  32  ALU operand A
o_alu_b  output  32  ALU operand B
o_alu_op  output  4  ALU op code, encodings from the team ALU macro header (ALU_ADD..ALU_AND)
i_alu_res  input  32  ALU result, combinational from o_alu_*
o_wb_vld  output  1  one-cycle writeback pulse
o_wb_rd  output  5  destination index for this writeback
o_wb_data  output  32  written value
o_illegal  output  1  one-cycle pulse: instruction rejected
i_dbg_addr  input  5  debug register read index
o_dbg_data  output  32  combinational read of reg[i_dbg_addr]; reads 0 for x0 and for indices >= NUM_REGS

Behaviour:
- Reset: i_rst_n sampled low at a clock edge causes:
  - every register cleared to 0
  - state = IDLE
  - o_alu_a/b/op, o_wb_*, o_illegal all 0
  - o_instr_rdy = 0 while i_rst_n is low
  - Reset mid-operation abandons the in-flight instruction: no register write, no pulse.
- FSM states:
  - IDLE: o_instr_rdy=1. On i_instr_vld & o_instr_rdy, latch i_instr and go to EXEC.
  - EXEC: o_instr_rdy=0. o_alu_* are driven from the decoded fields and the register read. At the end of this cycle, latch i_alu_res into o_wb_data and write reg[rd] (unless x0 or illegal). Go to WB.
  - WB: o_instr_rdy=0. o_wb_vld=1 (or o_illegal=1). Next state is IDLE.
- Timing:
  - Accept at edge E0 -> operands valid in the cycle after E0 -> pulse in the cycle after E1 -> rdy returns after E2.
  - Throughput is 1 instruction per 3 cycles.
  - No RAW hazard is possible, because a write always lands before the next accept.
- Decode, R-type (opcode 0110011):
  - funct7=0000000 with funct3 000..111 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0100000 with funct3=000 -> SUB; with funct3=101 -> SRA.
  - Any other funct7/funct3 combination is illegal.
  - A = reg[rs1], B = reg[rs2].
- Decode, I-type (opcode 0010011):
  - A = reg[rs1], B = sign-extended instr[31:20].
  - funct3 000/010/011/100/110/111 -> ADDI/SLTI/SLTIU/XORI/ORI/ANDI.
  - SLLI: funct3=001, funct7 must be 0000000.
  - SRLI: funct3=101, funct7=0000000. SRAI: funct3=101, funct7=0100000.
  - Any other shift funct7 is illegal.
- x0: always reads 0; writes are dropped. o_wb_vld still pulses with o_wb_rd=0 and o_wb_data = the ALU result.
- Illegal instruction:
  - o_alu_a = o_alu_b = 0, op = ALU_ADD during EXEC.
  - o_illegal pulses in WB, o_wb_vld stays 0, no register write.
  - o_wb_rd and o_wb_data hold their previous values.
- Handshake:
  - i_instr is sampled only on the accepting edge.
  - i_instr_vld held high while rdy=0 is legal and is not consumed.

Optional Feature:
ALU_ISSUE_LUI_EN
- Defined: opcode 0110111 (LUI) is legal: A=0, B={instr[31:12],12'b0}, op=ALU_ADD, normal writeback.
- Undefined: LUI decodes as illegal.

Test Plan:
- Reset, then ADDI x1,x0,5 -> o_wb_vld 2 cycles after the accept, o_wb_rd=1, o_wb_data=5; dbg x1 = 0x00000005.
- ADDI x2,x0,-8; SRAI x3,x2,1; SRLI x4,x2,28; SLT x5,x2,x1; SLTU x6,x2,x1 -> x3=0xFFFFFFFC, x4=0x0000000F, x5=1, x6=0.
- Instruction 0x00000000, then R-type ADD with funct7=0000001 -> o_illegal pulses each time, no o_wb_vld, all registers unchanged; with NUM_REGS=16, ADDI x20,x0,1 -> illegal.
- ADDI x0,x0,7 -> o_wb_vld=1, o_wb_rd=0, o_wb_data=7; dbg x0 = 0.
- i_instr_vld held high with two back-to-back ADDIs -> second accept exactly 3 cycles after the first; o_instr_rdy low in EXEC and WB.
- Accept ADDI x7,x0,9, drive i_rst_n low during EXEC -> no pulse, x7=0, IDLE with rdy=1 on the first cycle after reset release.
- With ALU_ISSUE_LUI_EN defined, LUI x8,0x12345 -> x8=0x12345000; without it -> o_illegal pulse.
